exe_stage_unit: RTL and testbench

- Execute stage that consumes the decoded control bundle (exe_cmd, mem_r_en, mem_w_en, wb_en, s, b) produced in decode.
- Performs the ALU operation and owns the NZCV status register.
- Computes branch targets and registers everything into the EXE/MEM pipeline register.
- Sits between the ID/EXE register and the memory stage; 1-cycle latency, with stall (freeze) and bubble (flush) control.

---
 rtl/exe_stage_unit.sv | 142 ++++++++++++++
 tb/tb_exe_stage_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_unit.sv
// Execute stage: ALU with NZCV status register, branch target computation and
// the EXE/MEM pipeline register, with freeze (stall) and flush (bubble) control.
module exe_stage_unit #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [3:0]        exe_cmd,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic              wb_en_in,
   input  logic              s_in,
   input  logic              b_in,
   input  logic [DATA_W-1:0] val_rn,
   input  logic [DATA_W-1:0] val2,
   input  logic [DATA_W-1:0] val_rm,
   input  logic [REG_W-1:0]  dest_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [23:0]       imm24,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] st_data,
   output logic [REG_W-1:0]  dest,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              wb_en,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_addr,
   output logic [3:0]        nzcv
);

   localparam int EXT_W = DATA_W - 26;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MVN = 4'b1001;

   logic [DATA_W-1:0] res;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] b_op;
   logic              cin;
   logic              is_arith;
   logic              is_sub;
   logic              c_new;
   logic              v_new;
   logic [3:0]        nzcv_new;
   logic [DATA_W-1:0] br_target;

   // Subtraction is rn + ~val2 + cin, so the carry out is directly NOT borrow.
   assign b_op = is_sub ? ~val2 : val2;
   assign sum  = {1'b0, val_rn} + {1'b0, b_op} + {{DATA_W{1'b0}}, cin};

   always_comb begin
      res      = '0;
      cin      = 1'b0;
      is_arith = 1'b0;
      is_sub   = 1'b0;
      case (exe_cmd)
         CMD_MOV: res = val2;
         CMD_MVN: res = ~val2;
         CMD_ADD: begin is_arith = 1'b1; res = sum[DATA_W-1:0]; end
         CMD_ADC: begin is_arith = 1'b1; cin = nzcv[1]; res = sum[DATA_W-1:0]; end
         CMD_SUB: begin is_arith = 1'b1; is_sub = 1'b1; cin = 1'b1; res = sum[DATA_W-1:0]; end
         CMD_SBC: begin is_arith = 1'b1; is_sub = 1'b1; cin = nzcv[1]; res = sum[DATA_W-1:0]; end
         CMD_AND: res = val_rn & val2;
         CMD_ORR: res = val_rn | val2;
         CMD_EOR: res = val_rn ^ val2;
         default: res = '0;
      endcase
   end

   always_comb begin
      c_new = nzcv[1];
      v_new = nzcv[0];
      if (is_arith) begin
         c_new = sum[DATA_W];
         if (is_sub)
            v_new = (val_rn[DATA_W-1] != val2[DATA_W-1]) && (res[DATA_W-1] != val_rn[DATA_W-1]);
         else
            v_new = (val_rn[DATA_W-1] == val2[DATA_W-1]) && (res[DATA_W-1] != val_rn[DATA_W-1]);
      end
      nzcv_new = {res[DATA_W-1], (res == '0), c_new, v_new};
   end

   assign br_target = pc_in + {{EXT_W{imm24[23]}}, imm24, 2'b00};

   // in_valid=0 acts as a bubble at load time; a held freeze keeps the stage intact.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_result <= '0;
         st_data    <= '0;
         dest       <= '0;
         mem_r_en   <= 1'b0;
         mem_w_en   <= 1'b0;
         wb_en      <= 1'b0;
         br_taken   <= 1'b0;
         br_addr    <= '0;
         nzcv       <= '0;
      end else if (flush || (!freeze && !in_valid)) begin
         alu_result <= '0;
         st_data    <= '0;
         dest       <= '0;
         mem_r_en   <= 1'b0;
         mem_w_en   <= 1'b0;
         wb_en      <= 1'b0;
         br_taken   <= 1'b0;
         br_addr    <= '0;
      end else if (!freeze) begin
         if (b_in) begin
            alu_result <= '0;
            st_data    <= '0;
            dest       <= '0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
            wb_en      <= 1'b0;
            br_taken   <= 1'b1;
            br_addr    <= br_target;
         end else begin
            alu_result <= res;
            st_data    <= val_rm;
            dest       <= dest_in;
            mem_r_en   <= mem_r_en_in;
            mem_w_en   <= mem_w_en_in;
            wb_en      <= wb_en_in;
            br_taken   <= 1'b0;
            br_addr    <= '0;
            if (s_in)
               nzcv <= nzcv_new;
         end
      end
   end

endmodule

// File: tb/tb_exe_stage_unit.sv
// Bench for exe_stage_unit: directed scenarios plus randomized traffic checked
// against an arithmetic reference model of the execute stage.
module tb_exe_stage_unit;

   logic        clk = 1'b0;
   logic        rst_n, freeze, flush, in_valid;
   logic [3:0]  exe_cmd;
   logic        mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in;
   logic [31:0] val_rn, val2, val_rm, pc_in;
   logic [3:0]  dest_in;
   logic [23:0] imm24;
   logic [31:0] alu_result, st_data, br_addr;
   logic [3:0]  dest, nzcv;
   logic        mem_r_en, mem_w_en, wb_en, br_taken;

   int checks = 0;
   int errors = 0;

   logic [31:0] e_alu, e_st, e_ba;
   logic [3:0]  e_dest, e_nzcv;
   logic        e_mr, e_mw, e_wb, e_bt;
   logic        e_chk_data, e_chk_ba;

   exe_stage_unit #(.DATA_W(32), .REG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .in_valid(in_valid),
      .exe_cmd(exe_cmd), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .wb_en_in(wb_en_in), .s_in(s_in), .b_in(b_in), .val_rn(val_rn), .val2(val2),
      .val_rm(val_rm), .dest_in(dest_in), .pc_in(pc_in), .imm24(imm24),
      .alu_result(alu_result), .st_data(st_data), .dest(dest), .mem_r_en(mem_r_en),
      .mem_w_en(mem_w_en), .wb_en(wb_en), .br_taken(br_taken), .br_addr(br_addr),
      .nzcv(nzcv)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference ALU from the arithmetic definition of each operation.
   function automatic void alu_ref(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                   input logic cf, input logic vf,
                                   output logic [31:0] r, output logic c, output logic v);
      longint ua, ub, sa, sb, uf, sf;
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = 32'h0; c = cf; v = vf; uf = 0; sf = 0;
      case (cmd)
         4'd1: r = b;
         4'd9: r = ~b;
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         4'd2, 4'd3: begin
            uf = ua + ub + ((cmd == 4'd3) ? longint'(cf) : 0);
            sf = sa + sb + ((cmd == 4'd3) ? longint'(cf) : 0);
            r = uf[31:0];
            c = (uf >= 64'sd4294967296);
         end
         4'd4, 4'd5: begin
            uf = ua - ub - ((cmd == 4'd5) ? (1 - longint'(cf)) : 0);
            sf = sa - sb - ((cmd == 4'd5) ? (1 - longint'(cf)) : 0);
            r = uf[31:0];
            c = (uf >= 0);
         end
         default: r = 32'h0;
      endcase
      if (cmd inside {4'd2, 4'd3, 4'd4, 4'd5})
         v = (sf > 64'sd2147483647) || (sf < -64'sd2147483648);
   endfunction

   task automatic bubble_model();
      e_alu = 0; e_st = 0; e_dest = 0; e_ba = 0;
      e_mr = 0; e_mw = 0; e_wb = 0; e_bt = 0;
      e_chk_data = 1; e_chk_ba = 0;
   endtask

   task automatic model_update();
      logic [31:0] r;
      logic        c, v;
      longint      tgt;
      if (!rst_n) begin
         bubble_model();
         e_nzcv = 0;
      end else if (flush) begin
         bubble_model();
      end else if (freeze) begin
         // everything holds
      end else if (!in_valid) begin
         bubble_model();
      end else if (b_in) begin
         bubble_model();
         tgt  = longint'({32'b0, pc_in}) + longint'($signed(imm24)) * 4;
         e_ba = tgt[31:0];
         e_bt = 1;
         e_chk_data = 0;
         e_chk_ba = 1;
      end else begin
         alu_ref(exe_cmd, val_rn, val2, e_nzcv[1], e_nzcv[0], r, c, v);
         e_alu = r; e_st = val_rm; e_dest = dest_in;
         e_mr = mem_r_en_in; e_mw = mem_w_en_in; e_wb = wb_en_in; e_bt = 0;
         e_chk_data = 1; e_chk_ba = 0;
         if (s_in) e_nzcv = {r[31], (r == 0), c, v};
      end
   endtask

   task automatic compare_all();
      check("alu_result", alu_result, e_alu);
      check("mem_r_en", 32'(mem_r_en), 32'(e_mr));
      check("mem_w_en", 32'(mem_w_en), 32'(e_mw));
      check("wb_en", 32'(wb_en), 32'(e_wb));
      check("br_taken", 32'(br_taken), 32'(e_bt));
      check("nzcv", 32'(nzcv), 32'(e_nzcv));
      if (e_chk_data) begin
         check("st_data", st_data, e_st);
         check("dest", 32'(dest), 32'(e_dest));
      end
      if (e_chk_ba) check("br_addr", br_addr, e_ba);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic set_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic r_en, input logic w_en, input logic wb);
      in_valid = 1; flush = 0; freeze = 0; b_in = 0;
      exe_cmd = cmd; val_rn = a; val2 = b; s_in = s;
      mem_r_en_in = r_en; mem_w_en_in = w_en; wb_en_in = wb;
   endtask

   function automatic logic [31:0] pick_val();
      logic [31:0] edge_vals [4];
      edge_vals[0] = 32'h0; edge_vals[1] = 32'hFFFF_FFFF;
      edge_vals[2] = 32'h7FFF_FFFF; edge_vals[3] = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   initial begin
      rst_n = 0; freeze = 0; flush = 0; in_valid = 0; exe_cmd = 0;
      mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0; s_in = 0; b_in = 0;
      val_rn = 0; val2 = 0; val_rm = 32'h1234_5678; dest_in = 4'd3; pc_in = 0; imm24 = 0;
      e_nzcv = 4'hF;
      step();
      step();
      check("reset_nzcv", 32'(nzcv), 32'h0);
      rst_n = 1;

      set_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 0, 0, 1);
      step();
      check("adds_ovf_res", alu_result, 32'h8000_0000);
      check("adds_ovf_nzcv", 32'(nzcv), 32'b1001);

      set_op(4'b0100, 32'd5, 32'd5, 1, 0, 0, 1);
      step();
      check("subs_eq_nzcv", 32'(nzcv), 32'b0110);
      set_op(4'b0101, 32'd10, 32'd3, 0, 0, 0, 1);
      step();
      check("sbc_res", alu_result, 32'd7);
      check("sbc_nzcv_kept", 32'(nzcv), 32'b0110);

      set_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 1);
      step();
      check("adds_carry_nzcv", 32'(nzcv), 32'b0110);
      set_op(4'b0011, 32'h0, 32'h0, 0, 0, 0, 1);
      step();
      check("adc_fwd_res", alu_result, 32'h1);

      set_op(4'b0010, 32'h1, 32'h1, 1, 0, 0, 1);
      b_in = 1; pc_in = 32'h100; imm24 = 24'hFFFFFE;
      step();
      check("br_addr_neg", br_addr, 32'hF8);
      check("br_taken_on", 32'(br_taken), 32'h1);
      check("br_nzcv_kept", 32'(nzcv), 32'b0110);
      set_op(4'b0110, 32'hF0, 32'h3C, 0, 0, 0, 1);
      step();
      check("br_taken_pulse", 32'(br_taken), 32'h0);

      set_op(4'b0010, 32'h40, 32'h8, 0, 1, 0, 1);
      val_rm = 32'hCAFE_0001;
      step();
      freeze = 1; val_rn = 32'h999; mem_r_en_in = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("freeze_alu", alu_result, 32'h48);
         check("freeze_mr", 32'(mem_r_en), 32'h1);
      end
      flush = 1;
      step();
      check("flush_freeze_mr", 32'(mem_r_en), 32'h0);
      check("flush_freeze_wb", 32'(wb_en), 32'h0);

      set_op(4'b0110, 32'hFFFF_0000, 32'h8000_FFFF, 1, 0, 0, 1);
      step();
      freeze = 1; rst_n = 0;
      step();
      check("rst_frozen_nzcv", 32'(nzcv), 32'h0);
      check("rst_frozen_alu", alu_result, 32'h0);
      rst_n = 1; freeze = 0;

      for (int n = 0; n < 3000; n++) begin
         rst_n       = ($urandom_range(0, 199) != 0);
         freeze      = ($urandom_range(0, 6) == 0);
         flush       = ($urandom_range(0, 9) == 0);
         in_valid    = freeze ? 1'b1 : ($urandom_range(0, 9) != 0);
         exe_cmd     = 4'($urandom_range(0, 15));
         b_in        = ($urandom_range(0, 7) == 0);
         s_in        = 1'($urandom);
         mem_r_en_in = 1'($urandom);
         mem_w_en_in = 1'($urandom);
         wb_en_in    = 1'($urandom);
         val_rn      = pick_val();
         val2        = pick_val();
         val_rm      = $urandom;
         dest_in     = 4'($urandom);
         pc_in       = $urandom;
         imm24       = 24'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
